// File: rtl/fnd_scan_display_if.sv
// Display-stage bus: time word, cursor and alert in from the timer;
// digit enables, segments and buzzer out to the board.
interface fnd_scan_display_if;
  logic [23:0] value;
  logic [1:0]  cursor_pos;
  logic        alert;
  logic [5:0]  an;
  logic [7:0]  seg;
  logic        buzzer;

  modport master (output value, cursor_pos, alert, input an, seg, buzzer);
  modport slave  (input value, cursor_pos, alert, output an, seg, buzzer);
endinterface

// File: rtl/fnd_scan_display.sv
// Six-digit multiplexed seven-segment driver with cursor blink,
// alert flash and piezo tone; every output is registered.
module fnd_scan_display #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int SCAN_HZ    = 6000,
  parameter int BLINK_HZ   = 2,
  parameter int TONE_HZ    = 2000,
  parameter int ALERT_SEC  = 3
) (
  input  logic              clk,
  input  logic              reset,
  fnd_scan_display_if.slave bus
);
  localparam int SLOT_LEN   = CLOCK_FREQ / SCAN_HZ;
  localparam int BLINK_HALF = CLOCK_FREQ / (2 * BLINK_HZ);
  localparam int TONE_HALF  = CLOCK_FREQ / (2 * TONE_HZ);
  localparam int ALERT_LEN  = ALERT_SEC * CLOCK_FREQ;
  localparam int SLOT_W     = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TONE_W     = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int ALERT_W    = $clog2(ALERT_LEN + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_LEN - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_HALF - 1);
  localparam logic [ALERT_W-1:0] ALERT_LOAD = ALERT_W'(ALERT_LEN);

  logic [SLOT_W-1:0]  slot_cnt;
  logic [2:0]         digit_idx;
  logic [23:0]        snap;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [TONE_W-1:0]  tone_cnt;
  logic [ALERT_W-1:0] alert_cnt;
  logic [5:0]         an_q;
  logic [7:0]         seg_q;
  logic               buzzer_q;

  logic               frame_start;
  logic [23:0]        cur_word;
  logic [3:0]         nibble;
  logic [1:0]         pair;
  logic [6:0]         glyph;
  logic               dp_n;
  logic               blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // The first slot of a frame shows the live word and latches it, so the
  // remaining five digits come from the same time word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      snap <= '0;
    else if (frame_start)
      snap <= bus.value;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // A retrigger restarts both the duration and the tone phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alert_cnt <= '0;
      tone_cnt  <= '0;
      buzzer_q  <= 1'b0;
    end else if (bus.alert) begin
      alert_cnt <= ALERT_LOAD;
      tone_cnt  <= '0;
      buzzer_q  <= 1'b1;
    end else if (alert_cnt != '0) begin
      alert_cnt <= alert_cnt - 1'b1;
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        buzzer_q <= ~buzzer_q;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end else begin
      buzzer_q <= 1'b0;
    end
  end

  always_comb begin
    frame_start = (digit_idx == 3'd0) && (slot_cnt == '0);
    cur_word    = frame_start ? bus.value : snap;
    nibble      = 4'hF;
    pair        = 2'd0;
    case (digit_idx)
      3'd0:    begin nibble = cur_word[3:0];   pair = 2'd1; end
      3'd1:    begin nibble = cur_word[7:4];   pair = 2'd1; end
      3'd2:    begin nibble = cur_word[11:8];  pair = 2'd2; end
      3'd3:    begin nibble = cur_word[15:12]; pair = 2'd2; end
      3'd4:    begin nibble = cur_word[19:16]; pair = 2'd3; end
      3'd5:    begin nibble = cur_word[23:20]; pair = 2'd3; end
      default: begin nibble = 4'hF;            pair = 2'd0; end
    endcase
    case (nibble)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
    // dp on digits 1 and 3 stands in for the hh:mm:ss colons.
    dp_n  = !((digit_idx == 3'd1) || (digit_idx == 3'd3));
    blank = !blink_on && ((alert_cnt != '0) ||
            ((bus.cursor_pos != 2'd0) && (bus.cursor_pos == pair)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= 6'h3F;
      seg_q <= 8'hFF;
    end else begin
      an_q  <= ~(6'b000001 << digit_idx);
      seg_q <= blank ? 8'hFF : {dp_n, glyph};
    end
  end

  assign bus.an     = an_q;
  assign bus.seg    = seg_q;
  assign bus.buzzer = buzzer_q;
endmodule

// File: tb/tb_fnd_scan_display.sv
// Self-checking bench for fnd_scan_display: cycle-indexed reference model
// built from slot/frame/blink/alert arithmetic, driven with random traffic.
module tb_fnd_scan_display;
  localparam int SLOT       = 10;
  localparam int FRAME      = 60;
  localparam int BLINK_HALF = 300;
  localparam int TONE_HALF  = 6;
  localparam int ALERT_LEN  = 1200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  fnd_scan_display_if bus();

  fnd_scan_display #(
    .CLOCK_FREQ(1200), .SCAN_HZ(120), .BLINK_HZ(2), .TONE_HZ(100), .ALERT_SEC(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          n = 0;
  int          last_load = 0;
  bit          has_load = 1'b0;
  bit          model_flash = 1'b0;
  logic [23:0] frame_val = '0;

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int cur_digit();
    return ((n - 1) / SLOT) % 6;
  endfunction

  function automatic logic [5:0] exp_an();
    logic [5:0] r;
    r = 6'h3F;
    r[cur_digit()] = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] exp_seg();
    int  digit;
    bit  blink_on;
    digit    = cur_digit();
    blink_on = (((n - 1) / BLINK_HALF) % 2) == 0;
    if (!blink_on && (model_flash || (int'(bus.cursor_pos) == digit / 2 + 1)))
      return 8'hFF;
    return {(digit == 1 || digit == 3) ? 1'b0 : 1'b1, glyph_of(frame_val[digit*4 +: 4])};
  endfunction

  function automatic logic exp_buz();
    int k;
    if (!has_load) return 1'b0;
    k = n - last_load;
    return (k <= ALERT_LEN) && (((k / TONE_HALF) % 2) == 0);
  endfunction

  // Advance one clock edge and update the model with the inputs sampled there.
  task automatic tick();
    @(posedge clk);
    n++;
    if ((n - 1) % FRAME == 0) frame_val = bus.value;
    model_flash = has_load && ((n - 1 - last_load) < ALERT_LEN);
    if (bus.alert) begin
      has_load  = 1'b1;
      last_load = n;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.alert = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    has_load = 1'b0;
    model_flash = 1'b0;
  endtask

  task automatic test_reset();
    bus.value = 24'h654321;
    bus.cursor_pos = 2'd0;
    bus.alert = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.an !== 6'h3F) begin errors++; $display("[TB] FAIL reset_an got=%h exp=3f", bus.an); end
    checks++; if (bus.seg !== 8'hFF) begin errors++; $display("[TB] FAIL reset_seg got=%h exp=ff", bus.seg); end
    checks++; if (bus.buzzer !== 1'b0) begin errors++; $display("[TB] FAIL reset_buzzer got=%b exp=0", bus.buzzer); end
    repeat (3) @(negedge clk);
    checks++; if (bus.an !== 6'h3F) begin errors++; $display("[TB] FAIL reset_hold_an got=%h exp=3f", bus.an); end
    reset = 1'b0;
    n = 0;
    has_load = 1'b0;
    tick();
    checks++; if (bus.an !== 6'b111110) begin errors++; $display("[TB] FAIL first_an got=%b exp=111110", bus.an); end
    checks++; if (bus.seg !== 8'hF9) begin errors++; $display("[TB] FAIL first_seg got=%h exp=f9", bus.seg); end
  endtask

  task automatic test_static_decode();
    while (n < 125) begin
      tick();
      checks++; if (bus.an !== exp_an()) begin errors++; $display("[TB] FAIL static_an n=%0d got=%b exp=%b", n, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("[TB] FAIL static_seg n=%0d got=%h exp=%h", n, bus.seg, exp_seg()); end
      if ((n - 1) % FRAME == 5) begin
        checks++; if (bus.seg !== 8'hF9) begin errors++; $display("[TB] FAIL static_d0 n=%0d got=%h exp=f9", n, bus.seg); end
      end
      if ((n - 1) % FRAME == 15) begin
        checks++; if (bus.seg !== 8'h24) begin errors++; $display("[TB] FAIL static_d1 n=%0d got=%h exp=24", n, bus.seg); end
      end
      if ((n - 1) % FRAME == 55) begin
        checks++; if (bus.seg !== 8'h82) begin errors++; $display("[TB] FAIL static_d5 n=%0d got=%h exp=82", n, bus.seg); end
      end
    end
  endtask

  task automatic test_cursor_blink();
    bus.cursor_pos = 2'd2;
    while (n < 700) begin
      tick();
      checks++; if (bus.an !== exp_an()) begin errors++; $display("[TB] FAIL cursor_an n=%0d got=%b exp=%b", n, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("[TB] FAIL cursor_seg n=%0d got=%h exp=%h", n, bus.seg, exp_seg()); end
      if (n > 300 && n <= 600 && (cur_digit() == 2 || cur_digit() == 3)) begin
        checks++; if (bus.seg !== 8'hFF) begin errors++; $display("[TB] FAIL cursor_blank n=%0d got=%h exp=ff", n, bus.seg); end
      end
      if (n > 600 && cur_digit() == 2) begin
        checks++; if (bus.seg !== 8'hB0) begin errors++; $display("[TB] FAIL cursor_return n=%0d got=%h exp=b0", n, bus.seg); end
      end
    end
    bus.cursor_pos = 2'd0;
  endtask

  task automatic test_snapshot();
    logic [7:0] old_glyph [6];
    old_glyph = '{8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82};
    bus.value = 24'h654321;
    do_reset();
    while (n < 32) tick();
    bus.value = 24'h000000;
    while (n < 120) begin
      tick();
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("[TB] FAIL snap_model n=%0d got=%h exp=%h", n, bus.seg, exp_seg()); end
      if (n <= 60 && cur_digit() >= 3) begin
        checks++; if (bus.seg !== old_glyph[cur_digit()]) begin errors++; $display("[TB] FAIL snap_old n=%0d got=%h exp=%h", n, bus.seg, old_glyph[cur_digit()]); end
      end
      if (n > 60) begin
        checks++; if (bus.seg !== ((cur_digit() == 1 || cur_digit() == 3) ? 8'h40 : 8'hC0)) begin
          errors++; $display("[TB] FAIL snap_new n=%0d got=%h", n, bus.seg);
        end
      end
    end
  endtask

  task automatic test_edge_hour10();
    bus.value = 24'h65432A;
    do_reset();
    while (n < 60) begin
      tick();
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("[TB] FAIL hex_model n=%0d got=%h exp=%h", n, bus.seg, exp_seg()); end
      if (cur_digit() == 0) begin
        checks++; if (bus.seg !== 8'hFF) begin errors++; $display("[TB] FAIL hex_blank n=%0d got=%h exp=ff", n, bus.seg); end
      end
    end
  endtask

  task automatic test_alert();
    bus.value = 24'h593212;
    bus.cursor_pos = 2'd0;
    do_reset();
    while (n < 2000) begin
      if (n == 50 || n == 650) bus.alert = 1'b1;
      if (n % 37 == 0) bus.value = $urandom;
      tick();
      bus.alert = 1'b0;
      checks++; if (bus.buzzer !== exp_buz()) begin errors++; $display("[TB] FAIL alert_buz n=%0d got=%b exp=%b", n, bus.buzzer, exp_buz()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("[TB] FAIL alert_seg n=%0d got=%h exp=%h", n, bus.seg, exp_seg()); end
      checks++; if (bus.an !== exp_an()) begin errors++; $display("[TB] FAIL alert_an n=%0d got=%b exp=%b", n, bus.an, exp_an()); end
      if (n == 52 || n == 1851) begin
        checks++; if (bus.buzzer !== 1'b1) begin errors++; $display("[TB] FAIL alert_tone_hi n=%0d got=%b exp=1", n, bus.buzzer); end
      end
      if (n == 57 || n == 1852) begin
        checks++; if (bus.buzzer !== 1'b0) begin errors++; $display("[TB] FAIL alert_tone_lo n=%0d got=%b exp=0", n, bus.buzzer); end
      end
    end
  endtask

  task automatic test_alert_reset();
    do_reset();
    while (n < 10) tick();
    bus.alert = 1'b1;
    tick();
    bus.alert = 1'b0;
    repeat (100) tick();
    checks++; if (bus.buzzer !== exp_buz()) begin errors++; $display("[TB] FAIL areset_pre n=%0d got=%b exp=%b", n, bus.buzzer, exp_buz()); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.buzzer !== 1'b0) begin errors++; $display("[TB] FAIL areset_async got=%b exp=0", bus.buzzer); end
    checks++; if (bus.an !== 6'h3F) begin errors++; $display("[TB] FAIL areset_an got=%h exp=3f", bus.an); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    has_load = 1'b0;
    model_flash = 1'b0;
    while (n < 400) begin
      tick();
      checks++; if (bus.buzzer !== 1'b0) begin errors++; $display("[TB] FAIL areset_quiet n=%0d got=%b exp=0", n, bus.buzzer); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("[TB] FAIL areset_seg n=%0d got=%h exp=%h", n, bus.seg, exp_seg()); end
    end
  endtask

  task automatic test_random();
    bus.value = $urandom;
    do_reset();
    while (n < 3000) begin
      if ($urandom_range(0, 39) == 0) bus.value = $urandom;
      if ($urandom_range(0, 199) == 0) bus.cursor_pos = 2'($urandom_range(0, 3));
      bus.alert = ($urandom_range(0, 799) == 0);
      tick();
      checks++; if (bus.an !== exp_an()) begin errors++; $display("[TB] FAIL rand_an n=%0d got=%b exp=%b", n, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin errors++; $display("[TB] FAIL rand_seg n=%0d got=%h exp=%h", n, bus.seg, exp_seg()); end
      checks++; if (bus.buzzer !== exp_buz()) begin errors++; $display("[TB] FAIL rand_buz n=%0d got=%b exp=%b", n, bus.buzzer, exp_buz()); end
    end
    bus.alert = 1'b0;
  endtask

  initial begin
    bus.value = '0;
    bus.cursor_pos = 2'd0;
    bus.alert = 1'b0;
    test_reset();
    test_static_decode();
    test_cursor_blink();
    test_snapshot();
    test_edge_hour10();
    test_alert();
    test_alert_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
